// File: rtl/writeback_vin_buffer.sv
// Sample-to-beat packer with beat FIFO and DDR burst write sequencer.
// Samples pack into wide beats that are written out in bursts of up to BURST_LEN beats.
module writeback_vin_buffer #(
    parameter int ADDR_WIDTH    = 30,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DATA_BITS = 256,
    parameter int BURST_LEN     = 128,
    parameter int FIFO_DEPTH    = 256,
    parameter int ADDR_STEP     = 8
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_i,
    input  logic                     wr_start_i,
    input  logic [ADDR_WIDTH-1:0]    wr_base_addr_i,
    input  logic                     data_vld_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     data_rdy_o,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic                     wr_ddr_req_o,
    output logic [7:0]               wr_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    wr_ddr_addr_o,
    input  logic                     wr_ddr_data_req_i,
    output logic [MEM_DATA_BITS-1:0] wr_ddr_data_o,
    input  logic                     wr_ddr_finish_i
);
    localparam int PACK = MEM_DATA_BITS / DATA_WIDTH;
    localparam int PW   = $clog2(PACK) + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} state_t;

    state_t                   state;
    logic [MEM_DATA_BITS-1:0] pack_reg;
    logic [MEM_DATA_BITS-1:0] pack_nxt;
    logic [MEM_DATA_BITS-1:0] beat_reg;
    logic [PW-1:0]            pack_cnt;
    logic [PW-1:0]            cnt_nxt;
    logic                     beat_vld;
    logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CW-1:0]            fifo_cnt;
    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [7:0]               popped;
    logic [7:0]               len_nxt;
    logic                     flushing;
    logic                     accept;
    logic                     flush_go;
    logic                     beat_done;
    logic                     pop;
    logic                     idle_fire;
    logic                     done_cond;

    assign data_rdy_o = (fifo_cnt <= CW'(FIFO_DEPTH - 2)) & ~flushing;
    assign accept     = data_vld_i & data_rdy_o;
    assign flush_go   = flush_i & ~flushing;
    assign busy_o     = (state != IDLE) | (fifo_cnt != '0) |
                        (pack_cnt != '0) | beat_vld;

    always_comb begin
        pack_nxt = pack_reg;
        cnt_nxt  = pack_cnt;
        if (accept) begin
            pack_nxt[int'(pack_cnt)*DATA_WIDTH +: DATA_WIDTH] = data_i;
            cnt_nxt = pack_cnt + PW'(1);
        end
    end

    // a flush closes out a partial beat; upper lanes are already zero
    assign beat_done = (cnt_nxt == PW'(PACK)) |
                       (flush_go & (cnt_nxt != '0));

    assign pop = ((state == REQ) | (state == DATA)) &
                 wr_ddr_data_req_i & ~wr_ddr_finish_i;

    // in flush mode wait for any pending beat so the burst takes it too
    assign idle_fire = (fifo_cnt >= CW'(BURST_LEN)) |
                       (flushing & (fifo_cnt != '0) & ~beat_vld &
                        (pack_cnt == '0));

    assign len_nxt = (fifo_cnt >= CW'(BURST_LEN)) ?
                     8'(BURST_LEN) : fifo_cnt[7:0];

    assign done_cond = flushing & (state == IDLE) & (fifo_cnt == '0) &
                       ~beat_vld & (pack_cnt == '0);

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            pack_reg <= '0;
            pack_cnt <= '0;
            beat_reg <= '0;
            beat_vld <= 1'b0;
        end else begin
            beat_vld <= beat_done;
            if (beat_done) begin
                beat_reg <= pack_nxt;
                pack_reg <= '0;
                pack_cnt <= '0;
            end else begin
                pack_reg <= pack_nxt;
                pack_cnt <= cnt_nxt;
            end
        end
    end

    always_ff @(posedge ddr_clk_i) begin
        if (beat_vld) mem[wr_ptr] <= beat_reg;
    end

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            wr_ddr_data_o <= '0;
        end else begin
            if (beat_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                wr_ddr_data_o <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + AW'(1);
            end
            unique case ({beat_vld, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            flushing     <= 1'b0;
            flush_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            flush_done_o <= done_cond;
            if (flush_go)       flushing <= 1'b1;
            else if (done_cond) flushing <= 1'b0;
            if (wr_start_i & ~busy_o)        overflow_o <= 1'b0;
            if (data_vld_i & ~data_rdy_o)    overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
        if (ddr_rst_i) begin
            state         <= IDLE;
            wr_ddr_req_o  <= 1'b0;
            wr_ddr_len_o  <= '0;
            wr_ddr_addr_o <= '0;
            cur_addr      <= '0;
            popped        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_start_i & ~busy_o) cur_addr <= wr_base_addr_i;
                    if (idle_fire) begin
                        state         <= REQ;
                        wr_ddr_req_o  <= 1'b1;
                        wr_ddr_len_o  <= len_nxt;
                        wr_ddr_addr_o <= cur_addr;
                        popped        <= '0;
                    end
                end
                REQ, DATA: begin
                    if (wr_ddr_finish_i) begin
                        state        <= IDLE;
                        wr_ddr_req_o <= 1'b0;
                        cur_addr     <= cur_addr + ADDR_WIDTH'(popped) *
                                        ADDR_WIDTH'(ADDR_STEP);
                    end else if (pop) begin
                        wr_ddr_req_o <= 1'b0;
                        popped       <= popped + 8'd1;
                        state <= (popped + 8'd1 == wr_ddr_len_o) ? WAIT : DATA;
                    end
                end
                WAIT: begin
                    if (wr_ddr_finish_i) begin
                        state    <= IDLE;
                        cur_addr <= cur_addr + ADDR_WIDTH'(popped) *
                                    ADDR_WIDTH'(ADDR_STEP);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeback_vin_buffer.sv
// Scoreboard bench for writeback_vin_buffer with a behavioural DDR burst controller.
module tb_writeback_vin_buffer;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MB = 256;

    typedef struct {
        logic [7:0]    len;
        logic [AW-1:0] addr;
    } burst_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          data_vld = 1'b0;
    logic [DW-1:0] data = '0;
    logic          data_rdy;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          busy;
    logic          overflow;
    logic          ddr_req;
    logic [7:0]    ddr_len;
    logic [AW-1:0] ddr_addr;
    logic          data_req = 1'b0;
    logic [MB-1:0] ddr_data;
    logic          finish = 1'b0;

    burst_t        burst_q[$];
    logic [MB-1:0] beat_q[$];
    int            n_run = 0;
    int            n_fail = 0;
    int            fd_cnt = 0;
    bit            ctl_en = 1'b0;
    int            abort_beat = -1;
    bit            abort_hit = 1'b0;

    always #5 clk = ~clk;

    writeback_vin_buffer dut (
        .ddr_clk_i         (clk),
        .ddr_rst_i         (rst),
        .wr_start_i        (wr_start),
        .wr_base_addr_i    (base_addr),
        .data_vld_i        (data_vld),
        .data_i            (data),
        .data_rdy_o        (data_rdy),
        .flush_i           (flush),
        .flush_done_o      (flush_done),
        .busy_o            (busy),
        .overflow_o        (overflow),
        .wr_ddr_req_o      (ddr_req),
        .wr_ddr_len_o      (ddr_len),
        .wr_ddr_addr_o     (ddr_addr),
        .wr_ddr_data_req_i (data_req),
        .wr_ddr_data_o     (ddr_data),
        .wr_ddr_finish_i   (finish)
    );

    task automatic chk(input string nm, input logic [MB-1:0] act,
                       input logic [MB-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_seq(input logic [31:0] base, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            logic [MB-1:0] b;
            b = '0;
            for (int j = 0; j < 8; j++) b[j*32 +: 32] = base + 32'(8*k + j);
            beat_q.push_back(b);
        end
    endtask

    task automatic exp_burst(input int len, input logic [AW-1:0] addr);
        burst_t x;
        x.len  = 8'(len);
        x.addr = addr;
        burst_q.push_back(x);
    endtask

    task automatic feed(input int n, input logic [31:0] base,
                        input int start_at);
        for (int i = 0; i < n; i++) begin
            data_vld = 1'b1;
            data     = base + 32'(i);
            wr_start = (i == start_at);
            if (i == start_at) base_addr = 30'h0DEAD00;
            tick();
        end
        data_vld = 1'b0;
        wr_start = 1'b0;
    endtask

    task automatic start(input logic [AW-1:0] a);
        base_addr = a;
        wr_start  = 1'b1;
        tick();
        wr_start  = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        int c;
        c = 0;
        while ((busy || beat_q.size() != 0 || burst_q.size() != 0) &&
               c < maxc) begin
            tick();
            c++;
        end
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_left"}, beat_q.size() + burst_q.size(), 0);
    endtask

    initial begin : ctl
        burst_t eb;
        int     n;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_en && ddr_req && !rst) begin
                if (burst_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL burst_extra: got len %0d addr %h want none",
                             ddr_len, ddr_addr);
                end else begin
                    eb = burst_q.pop_front();
                    chk("burst_len", ddr_len, eb.len);
                    chk("burst_addr", ddr_addr, eb.addr);
                end
                n = int'(ddr_len);
                data_req = 1'b1;
                for (int i = 0; i < n; i++) begin
                    tick();
                    if (i == n - 1) data_req = 1'b0;
                    if (beat_q.size() == 0) begin
                        n_run++;
                        n_fail++;
                        $display("FAIL beat_extra: got %h want none", ddr_data);
                    end else begin
                        chk("beat", ddr_data, beat_q.pop_front());
                    end
                    if (i == abort_beat) begin
                        data_req  = 1'b0;
                        abort_hit = 1'b1;
                        break;
                    end
                end
                if (!abort_hit) begin
                    finish = 1'b1;
                    tick();
                    finish = 1'b0;
                end
            end
        end
    end

    initial begin : fd_mon
        forever begin
            @(posedge clk);
            #1;
            if (flush_done) fd_cnt++;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            fd0;
        int            c;
        logic [MB-1:0] b1;
        tick(3);
        chk("rst_req", ddr_req, 0);
        chk("rst_len", ddr_len, 0);
        chk("rst_addr", ddr_addr, 0);
        chk("rst_data", ddr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_fdone", flush_done, 0);
        rst = 1'b0;
        tick(2);
        ctl_en = 1'b1;

        start(30'h100);
        exp_burst(128, 30'h100);
        exp_seq(32'h0, 128);
        feed(1024, 32'h0, -1);
        wait_done("t1", 600);

        exp_burst(2, 30'h500);
        exp_seq(32'hA000, 1);
        b1 = '0;
        for (int j = 0; j < 5; j++) b1[j*32 +: 32] = 32'hA008 + 32'(j);
        beat_q.push_back(b1);
        fd0 = fd_cnt;
        feed(13, 32'hA000, -1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("t3", 200);
        tick(10);
        chk("t3_fdone", fd_cnt - fd0, 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ef_early", flush_done, 0);
        tick();
        chk("ef_done", flush_done, 1);
        tick();
        chk("ef_once", flush_done, 0);

        exp_burst(128, 30'h510);
        exp_seq(32'h5000, 128);
        feed(1024, 32'h5000, 500);
        wait_done("t6", 600);

        start(30'h2000);
        ctl_en = 1'b0;
        feed(2040, 32'h0, -1);
        tick(5);
        chk("t2_rdy", data_rdy, 0);
        chk("t2_ovf0", overflow, 0);
        feed(8, 32'hBAD0, -1);
        chk("t2_ovf1", overflow, 1);
        exp_burst(128, 30'h2000);
        exp_burst(127, 30'h2400);
        exp_seq(32'h0, 255);
        fd0 = fd_cnt;
        ctl_en = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("t2", 1000);
        tick(5);
        chk("t2_fdone", fd_cnt - fd0, 1);

        start(30'h3FFFFE00);
        chk("t4_ovf_clr", overflow, 0);
        exp_burst(128, 30'h3FFFFE00);
        exp_burst(128, 30'h200);
        exp_seq(32'h10000, 256);
        feed(2048, 32'h10000, -1);
        wait_done("t4", 1000);

        start(30'h4000);
        exp_burst(128, 30'h4000);
        exp_seq(32'h20000, 128);
        abort_beat = 40;
        feed(1024, 32'h20000, -1);
        c = 0;
        while (!abort_hit && c < 600) begin
            tick();
            c++;
        end
        chk("t5_abort_seen", abort_hit, 1);
        rst = 1'b1;
        #2;
        chk("t5_req", ddr_req, 0);
        chk("t5_len", ddr_len, 0);
        chk("t5_addr", ddr_addr, 0);
        chk("t5_data", ddr_data, 0);
        chk("t5_busy_rst", busy, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("t5_busy_rel", busy, 0);
        beat_q.delete();
        burst_q.delete();
        abort_beat = -1;
        abort_hit  = 1'b0;
        start(30'h8000);
        exp_burst(128, 30'h8000);
        exp_seq(32'h30000, 128);
        feed(1024, 32'h30000, -1);
        wait_done("t5b", 600);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
